// File: rtl/block_slide_animator.sv
// block_slide_animator
// Slides a rectangular scenery block up or down by STEP_PX pixels per
// frame tick, streaming a BLK_W x (BLK_H+STEP_PX) redraw window one pixel
// per cycle and restoring the background in the rows the block vacated.
// The step position survives between runs so a block can rise and later sink.
// Optional feature macro: ANIM_CHAR_CARRY_EN -- adds the SPRITE hand-off
// state in which an external sprite drawer redraws the riding character.
module block_slide_animator #(
  parameter int BLK_W     = 20,
  parameter int BLK_H     = 23,
  parameter int ORIGIN_X  = 116,
  parameter int ORIGIN_Y  = 152,
  parameter int STEP_PX   = 3,
  parameter int NUM_STEPS = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic       frame_tick,
  input  logic [7:0] char_y,
  output logic [4:0] blk_rd_x,
  output logic [4:0] blk_rd_y,
  input  logic [2:0] blk_color,
  input  logic       blk_opaque,
  output logic [8:0] bg_rd_x,
  output logic [7:0] bg_rd_y,
  input  logic [2:0] bg_color,
  output logic       plot,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_color,
  output logic       spr_req,
  output logic [7:0] spr_y,
  input  logic       spr_done,
  output logic [4:0] step,
  output logic       busy,
  output logic       done
);

  localparam int         WIN_H    = BLK_H + STEP_PX;
  localparam logic [7:0] STEP8    = 8'(STEP_PX);
  localparam logic [7:0] ORG_Y8   = 8'(ORIGIN_Y);
  localparam logic [8:0] ORG_X9   = 9'(ORIGIN_X);
  localparam logic [4:0] STEP_MAX = 5'(NUM_STEPS);
  localparam logic [4:0] X_LAST   = 5'(BLK_W - 1);
  localparam logic [5:0] Y_LAST   = 6'(WIN_H - 1);
  localparam logic [5:0] Y_BLK    = 6'(BLK_H);
  localparam logic [5:0] Y_STEP   = 6'(STEP_PX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_DRAW   = 3'd2,
    ST_SPRITE = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t     state_r, state_s;
  logic [4:0] step_r;
  logic       dir_r;
  logic [4:0] x_r;
  logic [5:0] y_r;
  logic       addr_vld_r;
  logic       plot_r;
  logic [8:0] vga_x_r;
  logic [7:0] vga_y_r;
  logic       in_blk_r;

  logic [7:0] step_px_s;
  logic [7:0] win_top_s;
  logic       at_limit_s;
  logic       in_blk_s;
  logic [5:0] loc_y_s;

  // Window geometry: going down, the window starts at the old (higher) top,
  // so vacated rows come first; going up they trail the block.
  always_comb begin
    step_px_s = {3'd0, step_r} * STEP8;
    if (dir_r) begin
      win_top_s  = ORG_Y8 - step_px_s - STEP8;
      at_limit_s = (step_r == 5'd0);
      in_blk_s   = (y_r >= Y_STEP);
      loc_y_s    = y_r - Y_STEP;
    end else begin
      win_top_s  = ORG_Y8 - step_px_s;
      at_limit_s = (step_r == STEP_MAX);
      in_blk_s   = (y_r < Y_BLK);
      loc_y_s    = y_r;
    end
  end

  // ROM addressing from the raster counters; vacated rows park the block ROM at row 0.
  always_comb begin
    blk_rd_x = x_r;
    bg_rd_x  = ORG_X9 + {4'd0, x_r};
    bg_rd_y  = win_top_s + {2'd0, y_r};
    if (in_blk_s) begin
      blk_rd_y = loc_y_s[4:0];
    end else begin
      blk_rd_y = 5'd0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; dropping start abandons any state for IDLE.
  always_comb begin
    state_s = state_r;
    if ((state_r != ST_IDLE) && !start) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_s = ST_CHECK;
          else       state_s = ST_IDLE;
        end
        ST_CHECK: begin
          if (at_limit_s) state_s = ST_DONE;
          else            state_s = ST_DRAW;
        end
        ST_DRAW: begin
          if (addr_vld_r) begin
            state_s = ST_DRAW;
          end else begin
`ifdef ANIM_CHAR_CARRY_EN
            state_s = ST_SPRITE;
`else
            state_s = ST_WAIT;
`endif
          end
        end
`ifdef ANIM_CHAR_CARRY_EN
        ST_SPRITE: begin
          if (spr_done) state_s = ST_WAIT;
          else          state_s = ST_SPRITE;
        end
`endif
        ST_WAIT: begin
          if (frame_tick) state_s = ST_CHECK;
          else            state_s = ST_WAIT;
        end
        ST_DONE: state_s = ST_DONE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    case (state_r)
      ST_CHECK, ST_DRAW, ST_SPRITE, ST_WAIT: begin
        busy = 1'b1;
        done = 1'b0;
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
`ifdef ANIM_CHAR_CARRY_EN
    spr_req = (state_r == ST_SPRITE);
`else
    spr_req = 1'b0;
`endif
  end

`ifndef ANIM_CHAR_CARRY_EN
  logic unused_s;
  assign unused_s = spr_done;
`endif

  // Step update, raster counters and the one-stage pixel pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_r     <= 5'd0;
      dir_r      <= 1'b0;
      x_r        <= 5'd0;
      y_r        <= 6'd0;
      addr_vld_r <= 1'b0;
      plot_r     <= 1'b0;
      vga_x_r    <= 9'd0;
      vga_y_r    <= 8'd0;
      in_blk_r   <= 1'b0;
    end else begin
      plot_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) dir_r <= dir;
        end
        ST_CHECK: begin
          if (start && !at_limit_s) begin
            step_r     <= dir_r ? (step_r - 5'd1) : (step_r + 5'd1);
            x_r        <= 5'd0;
            y_r        <= 6'd0;
            addr_vld_r <= 1'b1;
          end
        end
        ST_DRAW: begin
          if (start && addr_vld_r) begin
            plot_r   <= 1'b1;
            vga_x_r  <= bg_rd_x;
            vga_y_r  <= bg_rd_y;
            in_blk_r <= in_blk_s;
            if (x_r == X_LAST) begin
              x_r <= 5'd0;
              if (y_r == Y_LAST) addr_vld_r <= 1'b0;
              else               y_r <= y_r + 6'd1;
            end else begin
              x_r <= x_r + 5'd1;
            end
          end else begin
            addr_vld_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Colour is chosen from ROM data that arrives alongside the registered strobe.
  always_comb begin
    if (plot_r) begin
      if (in_blk_r && blk_opaque) vga_color = blk_color;
      else                        vga_color = bg_color;
    end else begin
      vga_color = 3'd0;
    end
  end

  assign plot  = plot_r;
  assign vga_x = vga_x_r;
  assign vga_y = vga_y_r;
  assign step  = step_r;
  assign spr_y = char_y - ({3'd0, step_r} * STEP8);

endmodule
